// File: rtl/wb_sequencer_pkg.sv
// Shared encodings for the write-back sequencer: op codes, register-file mux
// selects, the FSM state type and the WRITE1 select decode.
package wb_sequencer_pkg;

    localparam logic [2:0] OP_RD_ALU = 3'd0;
    localparam logic [2:0] OP_RT_ALU = 3'd1;
    localparam logic [2:0] OP_RT_MEM = 3'd2;
    localparam logic [2:0] OP_LINK   = 3'd3;
    localparam logic [2:0] OP_PUSH   = 3'd4;
    localparam logic [2:0] OP_POP    = 3'd5;

    localparam logic [1:0] WREG_RT = 2'b00;
    localparam logic [1:0] WREG_SP = 2'b01;
    localparam logic [1:0] WREG_RA = 2'b10;
    localparam logic [1:0] WREG_RD = 2'b11;

    localparam logic [1:0] WDATA_ALU    = 2'b00;
    localparam logic [1:0] WDATA_MDR    = 2'b01;
    localparam logic [1:0] WDATA_PC4    = 2'b10;
    localparam logic [1:0] WDATA_SP_ADJ = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_MEM = 3'd1,
        ST_WRITE1   = 3'd2,
        ST_WRITE2   = 3'd3,
        ST_DONE     = 3'd4
    } wb_state_e;

    typedef struct packed {
        logic [1:0] wreg;
        logic [1:0] wdata;
    } wb_sel_t;

    function automatic wb_sel_t write1_sel(input logic [2:0] op);
        wb_sel_t sel;
        sel = '{wreg: WREG_RT, wdata: WDATA_ALU};
        case (op)
            OP_RD_ALU: sel = '{wreg: WREG_RD, wdata: WDATA_ALU};
            OP_RT_ALU: sel = '{wreg: WREG_RT, wdata: WDATA_ALU};
            OP_RT_MEM: sel = '{wreg: WREG_RT, wdata: WDATA_MDR};
            OP_LINK:   sel = '{wreg: WREG_RA, wdata: WDATA_PC4};
            OP_PUSH:   sel = '{wreg: WREG_SP, wdata: WDATA_ALU};
            OP_POP:    sel = '{wreg: WREG_RT, wdata: WDATA_MDR};
            default:   sel = '{wreg: WREG_RT, wdata: WDATA_ALU};
        endcase
        return sel;
    endfunction

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_RT_MEM) || (op == OP_POP);
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_POP;
    endfunction

endpackage

// File: rtl/wb_mem_timer.sv
// Wait counter for the memory-data state: held at zero while cleared, counts
// each waiting cycle and flags the last permitted cycle.
module wb_mem_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == CNT_W'(MEM_TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer: owns every register-file write of the multicycle datapath,
// driving address/data selects and RegWrite over one or two cycles per op.
module wb_sequencer
    import wb_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       mem_ready,
    input  logic       flush,
    output logic [1:0] wreg_sel,
    output logic [1:0] wdata_sel,
    output logic       reg_write,
    output logic       busy,
    output logic       done,
    output logic       err
);

    wb_state_e  state, state_nxt;
    logic [2:0] op_q, op_nxt;
    logic       err_q, err_nxt;
    logic       tmr_clear, tmr_count, tmr_expired;
    wb_sel_t    sel_w1;

    // Outside WAIT_MEM the counter is held at zero, so it always enters WAIT_MEM cleared.
    assign tmr_clear = (state != ST_WAIT_MEM);
    assign tmr_count = (state == ST_WAIT_MEM) && !mem_ready && !flush;

    wb_mem_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_mem_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tmr_clear),
        .count   (tmr_count),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            op_q  <= OP_RD_ALU;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            op_q  <= op_nxt;
            err_q <= err_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        err_nxt   = err_q;
        if (flush) begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_nxt = op;
                        if (is_mem_op(op)) begin
                            state_nxt = ST_WAIT_MEM;
                        end else if (is_legal_op(op)) begin
                            state_nxt = ST_WRITE1;
                        end else begin
                            state_nxt = ST_DONE;
                            err_nxt   = 1'b1;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    // A ready arriving on the expiry cycle still counts as success.
                    if (mem_ready) begin
                        state_nxt = ST_WRITE1;
                    end else if (tmr_expired) begin
                        state_nxt = ST_DONE;
                        err_nxt   = 1'b1;
                    end
                end
                ST_WRITE1: state_nxt = (op_q == OP_POP) ? ST_WRITE2 : ST_DONE;
                ST_WRITE2: state_nxt = ST_DONE;
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b0;
                end
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    assign sel_w1 = write1_sel(op_q);

    always_comb begin
        wreg_sel  = WREG_RT;
        wdata_sel = WDATA_ALU;
        reg_write = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_WAIT_MEM: begin
                wreg_sel  = sel_w1.wreg;
                wdata_sel = sel_w1.wdata;
            end
            ST_WRITE1: begin
                wreg_sel  = sel_w1.wreg;
                wdata_sel = sel_w1.wdata;
                reg_write = 1'b1;
            end
            ST_WRITE2: begin
                wreg_sel  = WREG_SP;
                wdata_sel = WDATA_SP_ADJ;
                reg_write = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: per-op expected output traces are built from the
// op/latency rules and compared cycle by cycle under randomized stimulus.
module tb_wb_sequencer;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [2:0] op;
    logic       mem_ready;
    logic       flush;
    logic [1:0] wreg_sel;
    logic [1:0] wdata_sel;
    logic       reg_write;
    logic       busy;
    logic       done;
    logic       err;

    wb_sequencer #(
        .MEM_TIMEOUT (T),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .mem_ready (mem_ready),
        .flush     (flush),
        .wreg_sel  (wreg_sel),
        .wdata_sel (wdata_sel),
        .reg_write (reg_write),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rw;
        logic [1:0] wreg;
        logic [1:0] wdata;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    int   compared   = 0;
    int   mismatched = 0;
    obs_t q[$];

    // WRITE1 selects per legal op, straight from the op table.
    logic [1:0] wreg_tab  [6] = '{2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
    logic [1:0] wdata_tab [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};

    function automatic obs_t mk(input logic rw, input logic [1:0] wr, input logic [1:0] wd,
                                input logic b, input logic d, input logic e);
        obs_t r;
        r.rw = rw; r.wreg = wr; r.wdata = wd; r.busy = b; r.done = d; r.err = e;
        return r;
    endfunction

    function automatic obs_t observe();
        return mk(reg_write, wreg_sel, wdata_sel, busy, done, err);
    endfunction

    function automatic bit is_mem(input logic [2:0] o);
        return (o == 3'd2) || (o == 3'd5);
    endfunction

    // Expected trace for cycles 1..N after start; d = cycle on which mem_ready is driven.
    task automatic build_model(input logic [2:0] o, input int d);
        int w;
        q.delete();
        if (o > 3'd5) begin
            q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1));
            return;
        end
        if (is_mem(o)) begin
            w = (d < T) ? d : T;
            for (int i = 0; i < w; i++)
                q.push_back(mk(1'b0, wreg_tab[o], wdata_tab[o], 1'b1, 1'b0, 1'b0));
            if (d > T) begin
                q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1));
                return;
            end
        end
        q.push_back(mk(1'b1, wreg_tab[o], wdata_tab[o], 1'b1, 1'b0, 1'b0));
        if (o == 3'd5)
            q.push_back(mk(1'b1, 2'b01, 2'b11, 1'b1, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0));
    endtask

    // Called just after a falling edge; returns in the IDLE cycle that follows done,
    // so a caller may start the next op immediately (back-to-back).
    task automatic run_txn(input string name, input logic [2:0] o, input int d, input bit junk);
        obs_t obs;
        int   w;
        build_model(o, d);
        w = is_mem(o) ? ((d < T) ? d : T) : 0;
        start     = 1'b1;
        op        = o;
        mem_ready = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int k = 1; k <= q.size(); k++) begin
            @(negedge clk);
            start     = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            op        = 3'($urandom_range(0, 7));
            mem_ready = (k <= w) ? (k == d) : (junk ? 1'($urandom_range(0, 1)) : 1'b0);
            obs = observe();
            compared++;
            if (obs !== q[k-1]) begin
                mismatched++;
                $display("FAIL %s op=%0d d=%0d cycle %0d: got %b want %b", name, o, d, k, obs, q[k-1]);
            end
        end
        @(negedge clk);
        start     = 1'b0;
        mem_ready = 1'b0;
        obs = observe();
        compared++;
        if (obs !== '0) begin
            mismatched++;
            $display("FAIL %s op=%0d idle-after-done: got %b want %b", name, o, obs, obs_t'('0));
        end
    endtask

    task automatic test_reset();
        obs_t obs;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        obs = observe();
        compared++;
        if (obs !== '0) begin
            mismatched++;
            $display("FAIL reset_idle: got %b want %b", obs, obs_t'('0));
        end
        reset_n = 1'b1;
        @(negedge clk);
        // POP with ready on cycle 1: cycle 2 is WRITE1, truncated by reset.
        start = 1'b1; op = 3'd5;
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        compared++;
        if (reg_write !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_pre_write1: got reg_write=%b want 1", reg_write);
        end
        #2 reset_n = 1'b0;
        #1 obs = observe();
        compared++;
        if (obs !== '0) begin
            mismatched++;
            $display("FAIL reset_async_drop: got %b want %b", obs, obs_t'('0));
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            obs = observe();
            compared++;
            if (obs !== '0) begin
                mismatched++;
                $display("FAIL reset_pop_abandoned: got %b want %b", obs, obs_t'('0));
            end
        end
    endtask

    task automatic test_rd_alu();
        run_txn("rd_alu", 3'd0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_link", 3'd3, 0, 1'b0);
        run_txn("b2b_push", 3'd4, 0, 1'b0);
    endtask

    task automatic test_pop();
        run_txn("pop", 3'd5, 3, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 3'd2, 1000, 1'b0);
        run_txn("timeout_ready_at_expiry", 3'd2, T, 1'b0);
    endtask

    task automatic test_illegal();
        run_txn("illegal7", 3'd7, 0, 1'b0);
        run_txn("illegal6", 3'd6, 0, 1'b1);
    endtask

    task automatic test_flush();
        obs_t obs;
        // flush beats start in IDLE
        start = 1'b1; op = 3'd0; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        repeat (2) begin
            obs = observe();
            compared++;
            if (obs !== '0) begin
                mismatched++;
                $display("FAIL flush_vs_start: got %b want %b", obs, obs_t'('0));
            end
            @(negedge clk);
        end
        // flush during WAIT_MEM
        start = 1'b1; op = 3'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; mem_ready = 1'b1;
        repeat (3) begin
            obs = observe();
            compared++;
            if (obs !== '0) begin
                mismatched++;
                $display("FAIL flush_wait_mem: got %b want %b", obs, obs_t'('0));
            end
            @(negedge clk);
            mem_ready = 1'b0;
        end
        // flush during POP WRITE1: first write stands, second never issued
        start = 1'b1; op = 3'd5;
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        compared++;
        if (reg_write !== 1'b1) begin
            mismatched++;
            $display("FAIL flush_pop_write1: got reg_write=%b want 1", reg_write);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        obs = observe();
        compared++;
        if (obs !== '0) begin
            mismatched++;
            $display("FAIL flush_pop_no_write2: got %b want %b", obs, obs_t'('0));
        end
        // err_q must be clean after a flushed op
        run_txn("after_flush", 3'd1, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0] o;
        int         d;
        for (int n = 0; n < 40; n++) begin
            o = 3'($urandom_range(0, 7));
            d = $urandom_range(1, T + 2);
            run_txn("random", o, d, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        op        = 3'd0;
        mem_ready = 1'b0;
        flush     = 1'b0;
        test_reset();
        test_rd_alu();
        test_back_to_back();
        test_pop();
        test_timeout();
        test_illegal();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
